// File: rtl/alu_mc.sv
// Multi-cycle ARM-style ALU with an internal NZCV register and a shift-add multiplier.
// Valid/ready on both sides; one request is in flight at a time.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         op,
  input  logic [2:0]         shift_op,
  input  logic               set_flags,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_AND = 5'h00, OP_EOR = 5'h01, OP_SUB = 5'h02, OP_RSB = 5'h03,
                         OP_ADD = 5'h04, OP_ADC = 5'h05, OP_SBC = 5'h06, OP_RSC = 5'h07,
                         OP_TST = 5'h08, OP_TEQ = 5'h09, OP_CMP = 5'h0A, OP_CMN = 5'h0B,
                         OP_ORR = 5'h0C, OP_SHF = 5'h0D, OP_BIC = 5'h0E, OP_MVN = 5'h0F,
                         OP_MUL = 5'h10;

  localparam logic [2:0] SH_LSL = 3'd1, SH_LSR = 3'd2, SH_ASR = 3'd3, SH_RRX = 3'd4, SH_ROR = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, acc_q, mcand_q, mplier_q;
  logic [3:0]         flags_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_sf_q;

  logic               accept, is_mul, c_in;
  logic [WIDTH-1:0]   add_x, add_y;
  logic               add_cin, add_v;
  logic [WIDTH:0]     sum;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     lsl_tmp, lsr_tmp;
  logic signed [WIDTH:0] asr_tmp;
  int                 rot_amt;
  logic [WIDTH-1:0]   ror_res, sh_res;
  logic               sh_c;
  logic [WIDTH-1:0]   val, alu_res;
  logic               keep, flag_we;
  logic [3:0]         alu_flags;

  assign accept = in_valid & in_ready;
  assign is_mul = (op == OP_MUL);
  assign c_in   = flags_q[1];
  assign shamt  = a[SHAMT_W-1:0];

  // Adder operands: subtraction is x + ~y + carry, so C naturally comes out as NOT borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; end
      OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1; end
      OP_ADC:         add_cin = c_in;
      OP_SBC:         begin add_y = ~b; add_cin = c_in; end
      OP_RSC:         begin add_x = b; add_y = ~a; add_cin = c_in; end
      default:        ;
    endcase
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
  end

  // The extra bit beside b catches the last bit shifted out, which is the shifter carry.
  always_comb begin
    lsl_tmp = {1'b0, b} << shamt;
    lsr_tmp = {b, 1'b0} >> shamt;
    asr_tmp = $signed({b, 1'b0}) >>> shamt;
    rot_amt = int'(shamt) % WIDTH;
    ror_res = (b >> rot_amt) | (b << (WIDTH - rot_amt));
    sh_res  = b;
    sh_c    = c_in;
    if (shift_op == SH_RRX) begin
      sh_res = {c_in, b[WIDTH-1:1]};
      sh_c   = b[0];
    end else if (shamt != '0) begin
      case (shift_op)
        SH_LSL:  {sh_c, sh_res} = lsl_tmp;
        SH_LSR:  {sh_res, sh_c} = lsr_tmp;
        SH_ASR:  {sh_res, sh_c} = asr_tmp;
        SH_ROR:  begin sh_res = ror_res; sh_c = ror_res[WIDTH-1]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    val       = '0;
    keep      = 1'b1;
    flag_we   = set_flags;
    alu_flags = flags_q;
    case (op)
      OP_AND:                begin val = a & b; end
      OP_EOR:                begin val = a ^ b; end
      OP_ORR:                begin val = a | b; end
      OP_BIC:                begin val = a & ~b; end
      OP_MVN:                begin val = ~b; end
      OP_TST:                begin val = a & b; keep = 1'b0; flag_we = 1'b1; end
      OP_TEQ:                begin val = a ^ b; keep = 1'b0; flag_we = 1'b1; end
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC: begin
        val            = sum[WIDTH-1:0];
        alu_flags[1:0] = {sum[WIDTH], add_v};
      end
      OP_CMP, OP_CMN: begin
        val            = sum[WIDTH-1:0];
        alu_flags[1:0] = {sum[WIDTH], add_v};
        keep           = 1'b0;
        flag_we        = 1'b1;
      end
      OP_SHF:                begin val = sh_res; alu_flags[1] = sh_c; end
      default:               begin flag_we = 1'b0; end
    endcase
    alu_flags[3:2] = {val[WIDTH-1], ~|val};
    alu_res        = keep ? val : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = is_mul ? S_MUL : S_DONE;
      S_MUL:   if (cnt_q == CNT_W'(WIDTH)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Multiplier runs WIDTH iterations, then spends one more edge publishing the product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mul_sf_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        S_IDLE: if (accept) begin
          if (is_mul) begin
            mcand_q  <= b;
            mplier_q <= a;
            acc_q    <= '0;
            cnt_q    <= '0;
            mul_sf_q <= set_flags;
          end else begin
            result_q <= alu_res;
            if (flag_we) flags_q <= alu_flags;
          end
        end
        S_MUL: if (cnt_q != CNT_W'(WIDTH)) begin
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end else begin
          result_q <= acc_q;
          if (mul_sf_q) flags_q[3:2] <= {acc_q[WIDTH-1], ~|acc_q};
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver pushes model predictions, a monitor pops and compares
// result, flags, latency and hold-stability whenever the ALU presents a result.
module tb_alu_mc;

  localparam int W  = 32;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, set_flags, out_valid, out_ready;
  logic [4:0]    op;
  logic [2:0]    shift_op;
  logic [W-1:0]  a, b, result;
  logic [3:0]    flags;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           acc_cyc;
    int           lat;
    int           bp;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mdl_flags;

  alu_mc #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .shift_op(shift_op), .set_flags(set_flags), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from integer semantics: C is carry-out or unsigned x >= y+borrow.
  function automatic void arith(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub,
                                input bit ex, output logic [W-1:0] r, output logic c, output logic v);
    longint ux, uy, sx, sy, s;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!sub) begin
      r = x + y + 32'(ex);
      c = (ux + uy + longint'(ex)) > longint'(32'hFFFF_FFFF);
      s = sx + sy + longint'(ex);
    end else begin
      r = x - y - 32'(ex);
      c = ux >= (uy + longint'(ex));
      s = sx - sy - longint'(ex);
    end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic ref_model(input logic [4:0] o, input logic [2:0] so, input logic sf,
                           input logic [W-1:0] x, input logic [W-1:0] y, output logic [W-1:0] res);
    logic nf, zf, cf, vf, c_old;
    logic [W-1:0] t;
    longint unsigned p;
    bit wr, cmp;
    int n, r;
    {nf, zf, cf, vf} = mdl_flags;
    c_old = cf;
    wr  = sf;
    cmp = 0;
    t   = '0;
    n   = int'(x[SW-1:0]);
    case (o)
      5'h00: t = x & y;
      5'h01: t = x ^ y;
      5'h0C: t = x | y;
      5'h0E: t = x & ~y;
      5'h0F: t = ~y;
      5'h08: begin t = x & y; cmp = 1; end
      5'h09: begin t = x ^ y; cmp = 1; end
      5'h02: arith(x, y, 1, 0, t, cf, vf);
      5'h03: arith(y, x, 1, 0, t, cf, vf);
      5'h04: arith(x, y, 0, 0, t, cf, vf);
      5'h05: arith(x, y, 0, c_old, t, cf, vf);
      5'h06: arith(x, y, 1, !c_old, t, cf, vf);
      5'h07: arith(y, x, 1, !c_old, t, cf, vf);
      5'h0A: begin arith(x, y, 1, 0, t, cf, vf); cmp = 1; end
      5'h0B: begin arith(x, y, 0, 0, t, cf, vf); cmp = 1; end
      5'h0D: begin
        t = y;
        case (so)
          3'd1: if (n > 0 && n < W) begin t = y << n; cf = y[W-n]; end
                else if (n == W) begin t = '0; cf = y[0]; end
                else if (n > W) begin t = '0; cf = 1'b0; end
          3'd2: if (n > 0 && n < W) begin t = y >> n; cf = y[n-1]; end
                else if (n == W) begin t = '0; cf = y[W-1]; end
                else if (n > W) begin t = '0; cf = 1'b0; end
          3'd3: if (n > 0 && n < W) begin t = $signed(y) >>> n; cf = y[n-1]; end
                else if (n >= W) begin t = {W{y[W-1]}}; cf = y[W-1]; end
          3'd4: begin t = {c_old, y[W-1:1]}; cf = y[0]; end
          3'd5: if (n != 0) begin
                  r = n % W;
                  if (r == 0) cf = y[W-1];
                  else begin t = (y >> r) | (y << (W - r)); cf = y[r-1]; end
                end
          default: ;
        endcase
      end
      5'h10: begin p = longint'({32'b0, x}) * longint'({32'b0, y}); t = p[W-1:0]; end
      default: wr = 0;
    endcase
    nf  = t[W-1];
    zf  = (t == '0);
    res = cmp ? '0 : t;
    if (wr || cmp) mdl_flags = {nf, zf, cf, vf};
  endtask

  task automatic issue(input logic [4:0] o, input logic [2:0] so, input logic sf,
                       input logic [W-1:0] x, input logic [W-1:0] y, input int bp);
    exp_t e;
    logic [W-1:0] r;
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", t);
      return;
    end
    in_valid = 1'b1; op = o; shift_op = so; set_flags = sf; a = x; b = y;
    ref_model(o, so, sf, x, y, r);
    e.res = r; e.fl = mdl_flags; e.acc_cyc = cyc + 1; e.bp = bp;
    e.lat = (o == 5'h10) ? W + 1 : 0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 5'($urandom); shift_op = 3'($urandom); set_flags = 1'($urandom);
    a = $urandom; b = $urandom;
    if (o == 5'h10) begin
      repeat (4) begin
        @(negedge clk);
        in_valid = 1'b1; op = 5'($urandom); a = $urandom; b = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"},    64'(result),    64'd0);
    check({tag, "_flags"},     64'(flags),     64'd0);
  endtask

  // Monitor / sink: pops the scoreboard on each new result and drives out_ready backpressure.
  initial begin
    exp_t cur;
    bit   seen = 0;
    int   hold = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        seen = 0; hold = 0; out_ready = 1'b1;
      end else if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_result: out_valid with empty scoreboard, result %0h", result);
          end else begin
            cur = sb.pop_front();
            check("result",  64'(result), 64'(cur.res));
            check("flags",   64'(flags),  64'(cur.fl));
            check("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
            hold = cur.bp;
          end
          seen = 1;
        end else begin
          check("hold_result",   64'(result),   64'(cur.res));
          check("hold_flags",    64'(flags),    64'(cur.fl));
          check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        if (hold > 0) begin out_ready = 1'b0; hold--; end
        else out_ready = 1'b1;
      end else begin
        if (seen && !out_ready) begin
          errors++; checks++;
          $display("FAIL early_release: out_valid dropped while out_ready=0");
        end
        seen = 0; out_ready = 1'b1;
      end
    end
  end

  initial begin
    logic [4:0]   o;
    logic [W-1:0] x, y;
    int t;
    reset_n = 1'b0; in_valid = 1'b0; op = '0; shift_op = '0; set_flags = 1'b0; a = '0; b = '0;
    mdl_flags = 4'b0000;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    issue(5'h04, 3'd0, 1, 32'h7FFF_FFFF, 32'h1, 0);            // ADD overflow
    issue(5'h02, 3'd0, 1, 32'd5, 32'd5, 0);                    // SUB 5-5
    issue(5'h06, 3'd0, 1, 32'd10, 32'd3, 0);                   // SBC with C=1
    issue(5'h0A, 3'd0, 0, 32'd0, 32'd1, 0);                    // CMP 0,1 -> C=0
    issue(5'h06, 3'd0, 1, 32'd10, 32'd3, 0);                   // SBC with C=0
    issue(5'h10, 3'd0, 1, 32'h0000_FFFF, 32'h0000_FFFF, 0);    // MUL
    issue(5'h0D, 3'd1, 1, 32'd32, 32'h1, 0);                   // LSL by WIDTH
    issue(5'h0D, 3'd2, 1, 32'd33, 32'h8000_0000, 0);           // LSR past WIDTH
    issue(5'h0D, 3'd5, 1, 32'd32, 32'h8000_0001, 0);           // ROR by WIDTH
    issue(5'h0D, 3'd4, 1, 32'd0, 32'h3, 0);                    // RRX with C=1
    issue(5'h04, 3'd0, 1, 32'h1234_5678, 32'h1111_1111, 5);    // backpressure
    issue(5'h04, 3'd0, 1, 32'd1, 32'd1, 0);

    // Reset in the middle of a multiply
    issue(5'h10, 3'd0, 1, 32'h0001_2345, 32'h0000_0777, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    mdl_flags = 4'b0000;
    #1 check_reset_values("midmul");
    @(negedge clk);
    reset_n = 1'b1;
    issue(5'h04, 3'd0, 1, 32'd2, 32'd3, 0);

    for (int i = 0; i < 250; i++) begin
      t = $urandom_range(0, 19);
      if (t < 16)       o = 5'(t);
      else if (t < 18)  o = 5'h10;
      else              o = 5'($urandom_range(17, 31));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h7FFF_FFFF;
        1: y = 32'h8000_0000;
        2: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (o == 5'h0D) begin
        case ($urandom_range(0, 6))
          0: x[SW-1:0] = 8'd0;
          1: x[SW-1:0] = 8'd1;
          2: x[SW-1:0] = 8'd31;
          3: x[SW-1:0] = 8'd32;
          4: x[SW-1:0] = 8'd33;
          5: x[SW-1:0] = 8'd64;
          default: x[SW-1:0] = 8'($urandom_range(0, 40));
        endcase
      end
      issue(o, 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), x, y, $urandom_range(0, 3));
    end

    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin @(negedge clk); t++; end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath's execute stage. Same ARM-style data-processing operation set as the single-cycle ALU, plus an iterative multiplier. Owns an internal NZCV flag register, so ADC/SBC/RSC/RRX/MOV read a registered carry instead of an external one. Valid/ready handshakes on both sides let the control unit stall on multi-cycle operations.

## Interface
Parameters:
- WIDTH, 32: operand and result width (≥ 8).
- SHAMT_W, 8: number of low bits of A used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  one clock; reset is asynchronous and active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  ALU can accept a request.
- op  input  5  operation: op[4]=0 gives the 16 data-processing codes (0000 AND, 0001 EOR, 0010 SUB, 0011 RSB, 0100 ADD, 0101 ADC, 0110 SBC, 0111 RSC, 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN, 1100 ORR, 1101 shift/MOV, 1110 BIC, 1111 MVN); 10000 is MUL; 10001–11111 are reserved.
- shift_op  input  3  with op=01101: 000 MOV, 001 LSL, 010 LSR, 011 ASR, 100 RRX, 101 ROR.
- set_flags  input  1  update the flag register (the S bit).
- a, b  input  WIDTH  operands. For shifts, b is the value and a[SHAMT_W-1:0] is the amount.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- flags  output  4  registered {N,Z,C,V}.

## Operation
- **FSM states.**
  - IDLE: in_ready=1.
  - MUL: in_ready=0, iterating.
  - DONE: out_valid=1, in_ready=0.
- **Accept.** A request is accepted when in_valid&in_ready at a clock edge. Operands, op, shift_op and set_flags are captured at that edge.
- **Transitions.**
  - Non-MUL op: IDLE→DONE, computed from the captured operands.
  - MUL: IDLE→MUL.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, then →DONE.
  - DONE→IDLE on out_ready. While out_ready=0, result and flags hold.
- **Arithmetic.**
  - Sums are computed at WIDTH+1 bits.
  - C uses ARM convention: add gives carry-out; subtract gives NOT borrow (C=1 iff minuend ≥ subtrahend, unsigned).
  - SBC = a−b−!C. RSC = b−a−!C. ADC = a+b+C.
  - V is signed overflow of the performed operation.
- **Logical ops (AND/EOR/ORR/BIC/MVN).** Update N and Z. C and V are unchanged.
- **Shifts (amount n = a[SHAMT_W-1:0]).**
  - n=0: result=b, C unchanged.
  - LSL: n<WIDTH gives C=b[WIDTH-n]. n=WIDTH gives C=b[0], result 0. n>WIDTH gives C=0, result 0.
  - LSR: n<WIDTH gives C=b[n-1]. n=WIDTH gives C=b[WIDTH-1], result 0. n>WIDTH gives C=0, result 0.
  - ASR: n≥WIDTH gives all-sign result, C=b[WIDTH-1].
  - ROR: rotate by n mod WIDTH. If that is 0 with n≠0: result=b, C=b[WIDTH-1].
  - RRX: result={C,b[WIDTH-1:1]}, C=b[0].
  - MOV: result=b, C unchanged.
  - V is unchanged for all shifts.
- **Compare ops (TST/TEQ/CMP/CMN).** Always update NZCV, regardless of set_flags. result=0. TST/TEQ affect N and Z only.
- **MUL.** result = low WIDTH bits of a*b. N and Z are updated; C and V are unchanged.
- **Flag register.** Written only when set_flags=1 or the op is a compare. The write occurs on the edge entering DONE.
- **Reserved op codes.** Single-cycle; result=0, flags unchanged.

## Timing
- **Reset values:** state IDLE, in_ready=1, out_valid=0, result=0, flags=4'b0000.
- **Reset mid-operation.** Asserting reset_n low in any state aborts it immediately. No flag update occurs.
- **Non-MUL latency.** Accept at edge k; out_valid=1 and result/flags valid after edge k. Back-to-back throughput is one op per 2 cycles.
- **MUL latency.** Accept at edge k; out_valid after edge k+WIDTH+1.
- **Requests while busy.** in_valid in MUL or DONE is ignored (in_ready=0). Input changes after acceptance have no effect.
- **Result/flags stability.** result and flags are registered outputs and stay stable while out_valid=1.
- **Carry dependency.** An op consumes the flag value present at its accept edge, which includes the previous op's update.

## Test plan
- **ADD with overflow.** ADD a=0x7FFFFFFF, b=1, set_flags=1 → result 0x80000000, flags 1001, out_valid one cycle after accept.
- **SUB then SBC chain.** SUB 5−5 with S gives result 0, flags 0110. Then SBC 10−3 gives 7 (C=1, no borrow). Repeat after CMP 0,1 (C=0): SBC 10−3 gives 6.
- **MUL latency and flags.** MUL 0xFFFF×0xFFFF → result 0xFFFE0001 with out_valid exactly WIDTH+1 edges after accept. C/V keep their prior values; in_valid pulses during MUL are ignored.
- **Shift boundary amounts.**
  - LSL b=1, n=32 → result 0, C=1.
  - LSR b=0x80000000, n=33 → result 0, C=0.
  - ROR b=0x80000001, n=32 → b unchanged, C=1.
  - RRX with C=1, b=0x3 → 0x80000001, C=1.
- **Backpressure.** Hold out_ready=0 for 5 cycles after an ADD → result, flags and out_valid are stable. The next request is accepted only in the cycle after out_ready=1.
- **Reset mid-MUL.** Pulse reset_n low at iteration 10 → outputs return to reset values. A following ADD 2+3 gives 5, flags 0000.
